tdm_demux14: RTL and testbench
==============================

TDM_DEMUX14 -- requirements
Module: tdm_demux14

Interface
REQ-001 Parameter: W, default 1, width in bits of one time slot on din and on each output o0..o3.
REQ-002 Port: clk  input  1  rising-edge clock; all state changes on this edge only.
REQ-003 Port: rst  input  1  reset, synchronous and active-high, sampled on rising clk.
REQ-004 Port: en  input  1  beat qualifier; din/fsync are sampled only when en=1.
REQ-005 Port: din  input  W  time-multiplexed slot data, one slot per qualified beat.
REQ-006 Port: fsync  input  1  frame marker; when 1 on a qualified beat, that beat is slot 0.
REQ-007 Port: o0, o1, o2, o3  output  W each  registered demultiplexed slot 0..3 data of the last complete frame.
REQ-008 Port: valid  output  1  one-cycle pulse: o0..o3 updated this cycle.
REQ-009 Port: s1, s0  output  1 each  registered index of the slot expected on the next qualified beat (s1 = MSB).
REQ-010 Port: locked  output  1  1 while the FSM is in RUN.
REQ-011 Port: sync_err  output  1  one-cycle pulse: fsync arrived mid-frame.
REQ-012 Port: perr  output  1  one-cycle pulse alongside valid on parity mismatch (see Configuration).

Function
REQ-013 The FSM shall have exactly two states: HUNT and RUN.
REQ-014 HUNT: beats with fsync=0 are discarded; a qualified beat with fsync=1 shall store din as slot 0, set slot index to 1, and enter RUN.
REQ-015 RUN: each qualified beat shall store din into the shadow register of the current slot and advance the slot index by one.
REQ-016 en=0 shall hold the slot index, the shadow registers, the outputs and the FSM state; valid, sync_err and perr are 0.
REQ-017 On the qualified beat carrying the last slot, o0..o3 shall load {shadow0, shadow1, shadow2, slot-3 data} simultaneously; valid=1 in the cycle after that edge (latency: 1 clk from last beat).
REQ-018 After the last slot the index shall wrap to 0; the FSM stays in RUN, and fsync at slot 0 is optional (free-running frames).
REQ-019 fsync=1 on a qualified beat in RUN with slot index != 0 shall discard the partial frame, store din as slot 0, set index to 1, and pulse sync_err for one cycle; o0..o3 keep their old values.
REQ-020 fsync=1 on the final-slot beat is a mid-frame event: REQ-019 applies and no valid is issued for that frame.
REQ-021 o0..o3 shall change only on valid cycles (frame-atomic update; no partial frame ever visible).
REQ-022 s1,s0 shall show 0 in HUNT.

Reset
REQ-023 rst=1 at a clock edge shall force HUNT, slot index 0, all shadow registers 0, o0..o3 = 0, and valid/sync_err/perr/locked = 0, overriding en, including mid-frame.
REQ-024 The first edge with rst=0 shall behave as in HUNT; no frame data from before reset shall ever reach o0..o3.

Configuration
REQ-025 Macro TDM_DEMUX14_PARITY_EN defined: the frame shall be 5 slots; slot 4 carries an even-parity bit in din[0] over the 4*W data bits; o0..o3/valid update on the slot-4 beat; perr=1 with valid when the XOR of the data bits and the parity bit is 1; outputs update regardless of perr.
REQ-026 Macro not defined: the frame shall be 4 slots, perr shall be constant 0, and no parity logic shall be present.

Verification
REQ-027 W=1, no parity: en=1 continuously, fsync on first beat, din=1,0,1,1 -> o0..o3=1,0,1,1, valid high exactly one cycle after the 4th beat, locked=1.
REQ-028 Stall: same frame with en=0 for 3 cycles between beats 2 and 3 -> identical outputs; valid delayed by 3 cycles; s1,s0 hold 2'b10 during the stall.
REQ-029 Resync: fsync with din=1,1, then fsync again with din=0,0,1,0 -> sync_err pulse on the second fsync, o0..o3=0,0,1,0, exactly one valid.
REQ-030 Reset mid-frame: 2 beats, then rst for 1 cycle, then din=1,1,1,1 without fsync -> locked=0, no valid, outputs remain 0.
REQ-031 PARITY_EN: din=1,0,0,0, parity 0 -> perr=1 with valid; parity 1 -> perr=0; o0..o3=1,0,0,0 in both cases.
REQ-032 HUNT: 6 qualified beats with fsync=0 -> no valid, locked=0, s1,s0=0.

Source files
------------

// File: rtl/tdm_demux14.sv
// TDM demultiplexer: 4 slots of W bits per frame into frame-atomic registered outputs.
// Optional TDM_DEMUX14_PARITY_EN adds a fifth even-parity slot and the perr flag.
module tdm_demux14 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  input  logic         fsync,
  output logic [W-1:0] o0,
  output logic [W-1:0] o1,
  output logic [W-1:0] o2,
  output logic [W-1:0] o3,
  output logic         valid,
  output logic         s1,
  output logic         s0,
  output logic         locked,
  output logic         sync_err,
  output logic         perr
);

`ifdef TDM_DEMUX14_PARITY_EN
  localparam int         NSH  = 4;
  localparam logic [2:0] LAST = 3'd4;
`else
  localparam int         NSH  = 3;
  localparam logic [2:0] LAST = 3'd3;
`endif

  typedef enum logic {HUNT, RUN} state_t;

  state_t       st_q, st_d;
  logic [2:0]   idx_q, idx_d;
  logic [W-1:0] sh_q [NSH];
  logic [W-1:0] sh_d [NSH];
  logic [W-1:0] o_q  [4];
  logic [W-1:0] o_d  [4];
  logic         valid_q, valid_d;
  logic         serr_q, serr_d;
`ifdef TDM_DEMUX14_PARITY_EN
  logic         perr_q, perr_d;
`endif

  always_comb begin
    st_d    = st_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    o_d     = o_q;
    valid_d = 1'b0;
    serr_d  = 1'b0;
`ifdef TDM_DEMUX14_PARITY_EN
    perr_d  = 1'b0;
`endif
    if (en) begin
      // fsync anywhere but slot 0 restarts the frame
      if (fsync && (st_q == HUNT || idx_q != 3'd0)) begin
        sh_d[0] = din;
        idx_d   = 3'd1;
        st_d    = RUN;
        serr_d  = (st_q == RUN);
      end else if (st_q == RUN) begin
        if (idx_q == LAST) begin
          idx_d   = 3'd0;
          valid_d = 1'b1;
          o_d[0]  = sh_q[0];
          o_d[1]  = sh_q[1];
          o_d[2]  = sh_q[2];
`ifdef TDM_DEMUX14_PARITY_EN
          o_d[3]  = sh_q[3];
          perr_d  = ^{sh_q[0], sh_q[1], sh_q[2], sh_q[3], din[0]};
`else
          o_d[3]  = din;
`endif
        end else begin
          for (int k = 0; k < NSH; k++) begin
            if (idx_q == 3'(k)) sh_d[k] = din;
          end
          idx_d = idx_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= HUNT;
      idx_q   <= 3'd0;
      valid_q <= 1'b0;
      serr_q  <= 1'b0;
      for (int k = 0; k < NSH; k++) sh_q[k] <= '0;
      for (int k = 0; k < 4; k++) o_q[k] <= '0;
`ifdef TDM_DEMUX14_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      st_q    <= st_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      serr_q  <= serr_d;
      sh_q    <= sh_d;
      o_q     <= o_d;
`ifdef TDM_DEMUX14_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign o0       = o_q[0];
  assign o1       = o_q[1];
  assign o2       = o_q[2];
  assign o3       = o_q[3];
  assign valid    = valid_q;
  assign sync_err = serr_q;
  assign s1       = idx_q[1];
  assign s0       = idx_q[0];
  assign locked   = (st_q == RUN);
`ifdef TDM_DEMUX14_PARITY_EN
  assign perr     = perr_q;
`else
  assign perr     = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux14.sv
// Bench for tdm_demux14: queue-based frame model, directed cases, random traffic.
// Honours TDM_DEMUX14_PARITY_EN in the same way as the design.
module tb_tdm_demux14;
  localparam int W = 2;
`ifdef TDM_DEMUX14_PARITY_EN
  localparam int NS = 5;
`else
  localparam int NS = 4;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         fsync = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] o0, o1, o2, o3;
  logic         valid, s1, s0, locked, sync_err, perr;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  tdm_demux14 #(.W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .fsync(fsync),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .valid(valid),
    .s1(s1), .s0(s0), .locked(locked), .sync_err(sync_err),
    .perr(perr)
  );

  always #5 clk = ~clk;

  // Model: collected slots of the frame in progress, plus last complete frame.
  bit           m_hunt = 1'b1;
  logic [W-1:0] m_cur [$];
  logic [W-1:0] m_o [4];
  bit           m_valid, m_serr, m_perr;

  always @(posedge clk) begin
    m_valid = 1'b0;
    m_serr  = 1'b0;
    m_perr  = 1'b0;
    if (rst) begin
      m_hunt = 1'b1;
      m_cur.delete();
      for (int k = 0; k < 4; k++) m_o[k] = '0;
    end else if (en) begin
      if (fsync && (m_hunt || m_cur.size() != 0)) begin
        m_serr = !m_hunt;
        m_hunt = 1'b0;
        m_cur.delete();
        m_cur.push_back(din);
      end else if (!m_hunt) begin
        m_cur.push_back(din);
        if (m_cur.size() == NS) begin
          bit p;
          p = 1'b0;
          for (int k = 0; k < 4; k++) begin
            m_o[k] = m_cur[k];
            p ^= ^m_cur[k];
          end
          if (NS == 5) m_perr = p ^ m_cur[NS-1][0];
          m_valid = 1'b1;
          m_cur.delete();
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      logic [1:0] es;
      es = m_hunt ? 2'd0 : 2'(m_cur.size());
      chk("o0", 32'(o0), 32'(m_o[0]));
      chk("o1", 32'(o1), 32'(m_o[1]));
      chk("o2", 32'(o2), 32'(m_o[2]));
      chk("o3", 32'(o3), 32'(m_o[3]));
      chk("valid", 32'(valid), 32'(m_valid));
      chk("sync_err", 32'(sync_err), 32'(m_serr));
      chk("perr", 32'(perr), 32'(m_perr));
      chk("locked", 32'(locked), 32'(!m_hunt));
      chk("slot", 32'({s1, s0}), 32'(es));
    end
  end

  task automatic step(bit e, bit f, logic [W-1:0] d);
    en = e;
    fsync = f;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    step(1'b1, 1'b0, '0);
    rst = 1'b0;
  endtask

  task automatic pin_out(string nm, logic [3:0] bits, bit v);
    @(negedge clk);
    chk({nm, "_o0"}, 32'(o0), 32'(bits[3]));
    chk({nm, "_o1"}, 32'(o1), 32'(bits[2]));
    chk({nm, "_o2"}, 32'(o2), 32'(bits[1]));
    chk({nm, "_o3"}, 32'(o3), 32'(bits[0]));
    chk({nm, "_valid"}, 32'(valid), 32'(v));
  endtask

  initial begin
    do_rst();
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);

`ifndef TDM_DEMUX14_PARITY_EN
    // Basic frame 1,0,1,1
    step(1, 1, 2'd1); step(1, 0, 2'd0); step(1, 0, 2'd1); step(1, 0, 2'd1);
    pin_out("basic", 4'b1011, 1'b1);
    chk("basic_locked", 32'(locked), 32'd1);
    step(0, 0, 2'd0);
    pin_out("basic_after", 4'b1011, 1'b0);

    // Stall between beats 2 and 3
    do_rst();
    step(1, 1, 2'd1); step(1, 0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 2'd3);
      chk("stall_slot", 32'({s1, s0}), 32'd2);
      chk("stall_valid", 32'(valid), 32'd0);
    end
    step(1, 0, 2'd1); step(1, 0, 2'd1);
    pin_out("stall", 4'b1011, 1'b1);

    // Resync mid-frame
    do_rst();
    step(1, 1, 2'd1); step(1, 0, 2'd1); step(1, 1, 2'd0);
    @(negedge clk);
    chk("resync_serr", 32'(sync_err), 32'd1);
    step(1, 0, 2'd0); step(1, 0, 2'd1); step(1, 0, 2'd0);
    pin_out("resync", 4'b0010, 1'b1);

    // Reset mid-frame, then data without fsync
    step(1, 1, 2'd1); step(1, 0, 2'd1);
    do_rst();
    for (int i = 0; i < 4; i++) step(1, 0, 2'd1);
    pin_out("rstmid", 4'b0000, 1'b0);
    chk("rstmid_locked", 32'(locked), 32'd0);
`else
    // Parity 0 over data 1,0,0,0 is wrong, parity 1 is right
    step(1, 1, 2'd1); step(1, 0, 2'd0); step(1, 0, 2'd0); step(1, 0, 2'd0);
    step(1, 0, 2'd0);
    pin_out("par0", 4'b1000, 1'b1);
    chk("par0_perr", 32'(perr), 32'd1);
    step(1, 0, 2'd1); step(1, 0, 2'd0); step(1, 0, 2'd0); step(1, 0, 2'd0);
    step(1, 0, 2'd1);
    pin_out("par1", 4'b1000, 1'b1);
    chk("par1_perr", 32'(perr), 32'd0);
`endif

    // HUNT ignores unsynchronised beats
    do_rst();
    for (int i = 0; i < 6; i++) step(1, 0, W'($urandom));
    @(negedge clk);
    chk("hunt_locked", 32'(locked), 32'd0);
    chk("hunt_slot", 32'({s1, s0}), 32'd0);
    chk("hunt_valid", 32'(valid), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
           W'($urandom));
    end
    rst = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
